// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: drains a show-ahead FIFO into a valid/ready stream framed with SOP/EOP
module fifo_pkt_reader #(
  parameter int width = 8,
  parameter int maxlen = 4,
  parameter int cntw = 2,
  parameter int timeout = 8,
  parameter int tmrw = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [width-1:0] FIFO_Q,
  input  logic             FIFO_EMPTY,
  output logic             FIFO_RD,
  input  logic             FLUSH,
  output logic [width-1:0] TX_DATA,
  output logic             TX_VALID,
  output logic             TX_SOP,
  output logic             TX_EOP,
  input  logic             TX_READY
);
  logic [width-1:0] r_hold, r_tx_data;
  logic             r_hold_v, r_flush_p, r_tx_valid, r_tx_sop, r_tx_eop;
  logic [cntw-1:0]  r_bcnt;
  logic [tmrw-1:0]  r_tmr;
  logic             w_tx_free, w_close, w_rel, w_rd;
  assign w_tx_free = ~r_tx_valid | TX_READY;
  assign w_close   = (r_bcnt == cntw'(maxlen - 1)) | (r_tmr == tmrw'(timeout)) | r_flush_p | FLUSH;
  assign w_rel     = r_hold_v & w_tx_free & (w_close | ~FIFO_EMPTY);
  assign w_rd      = nRST & ~FIFO_EMPTY & (~r_hold_v | w_rel);
  assign FIFO_RD   = w_rd;
  assign TX_DATA   = r_tx_data;
  assign TX_VALID  = r_tx_valid;
  assign TX_SOP    = r_tx_sop;
  assign TX_EOP    = r_tx_eop;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_hold     <= '0;
      r_hold_v   <= 1'b0;
      r_bcnt     <= '0;
      r_tmr      <= '0;
      r_flush_p  <= 1'b0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_tx_sop   <= 1'b0;
      r_tx_eop   <= 1'b0;
    end else begin
      if (w_rd) r_hold <= FIFO_Q;
      r_hold_v <= w_rd | (r_hold_v & ~w_rel);
      if (w_rel) begin
        r_tx_data <= r_hold;
        r_tx_sop  <= (r_bcnt == '0);
        r_tx_eop  <= w_close;
        r_bcnt    <= w_close ? '0 : r_bcnt + 1'b1;
      end
      r_tx_valid <= w_rel | (r_tx_valid & ~TX_READY);
      r_tmr      <= (w_rd | ~r_hold_v) ? '0 :
                    (FIFO_EMPTY & (r_tmr != tmrw'(timeout))) ? r_tmr + 1'b1 : r_tmr;
      r_flush_p  <= (w_rel & w_close) ? 1'b0 : (r_flush_p | (FLUSH & r_hold_v));
    end
  a_idle_bcnt: assert property (@(posedge CLK) disable iff (!nRST) !r_hold_v |-> r_bcnt == '0);
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// tb_fifo_pkt_reader: FIFO model plus scoreboard of expected framed beats
module tb_fifo_pkt_reader;
  localparam int W = 8, ML = 4, TO = 8;
  logic CLK = 0, nRST = 0, FIFO_EMPTY = 1, FLUSH = 0, TX_READY = 1;
  logic [W-1:0] FIFO_Q = '0;
  logic FIFO_RD, TX_VALID, TX_SOP, TX_EOP;
  logic [W-1:0] TX_DATA;
  typedef struct packed {logic [W-1:0] d; logic s; logic e;} beat_t;
  beat_t exp_q[$];
  logic [W-1:0] fq[$];
  int acc_cyc[$];
  int cyc_n = 0, tests = 0, fails = 0;
  always #5 CLK = ~CLK;
  fifo_pkt_reader #(.width(W), .maxlen(ML), .cntw(2), .timeout(TO), .tmrw(4)) dut (
    .CLK(CLK), .nRST(nRST), .FIFO_Q(FIFO_Q), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_RD(FIFO_RD),
    .FLUSH(FLUSH), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_SOP(TX_SOP),
    .TX_EOP(TX_EOP), .TX_READY(TX_READY)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic refresh();
    FIFO_EMPTY = (fq.size() == 0);
    FIFO_Q = FIFO_EMPTY ? '0 : fq[0];
  endtask
  task automatic push(input logic [W-1:0] d);
    fq.push_back(d);
    refresh();
  endtask
  task automatic expb(input logic [W-1:0] d, input logic s, input logic e);
    exp_q.push_back('{d: d, s: s, e: e});
  endtask
  task automatic cyc();
    logic rd;
    beat_t b;
    @(negedge CLK);
    if (FIFO_RD) chk("rd_when_empty", FIFO_EMPTY, 0);
    if (TX_VALID && TX_READY) begin
      acc_cyc.push_back(cyc_n);
      chk("beat_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("tx_data", TX_DATA, b.d);
        chk("tx_sop", TX_SOP, b.s);
        chk("tx_eop", TX_EOP, b.e);
      end
    end
    rd = FIFO_RD;
    @(posedge CLK);
    cyc_n++;
    #1;
    if (rd) void'(fq.pop_front());
    refresh();
    FLUSH = 0;
  endtask
  task automatic drain(input int max);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max) begin
      cyc();
      n++;
    end
    chk("drain_done", exp_q.size(), 0);
    repeat (2) cyc();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0, fc;
    refresh();
    repeat (3) cyc();
    chk("rst_valid", TX_VALID, 0);
    chk("rst_sop", TX_SOP, 0);
    chk("rst_eop", TX_EOP, 0);
    chk("rst_data", TX_DATA, 0);
    chk("rst_rd", FIFO_RD, 0);
    nRST = 1;
    repeat (2) cyc();
    acc_cyc.delete();
    for (int i = 0; i < 8; i++) begin
      push(W'(8'h10 + i));
      expb(W'(8'h10 + i), (i % 4) == 0, (i % 4) == 3);
    end
    drain(30);
    chk("t1_beats", acc_cyc.size(), 8);
    chk("t1_no_bubble", acc_cyc[7] - acc_cyc[0], 7);
    acc_cyc.delete();
    push(8'h21); push(8'h22);
    expb(8'h21, 1, 0); expb(8'h22, 0, 1);
    drain(40);
    chk("t2_timeout_gap", acc_cyc[1] - acc_cyc[0], TO + 1);
    acc_cyc.delete();
    push(8'h31);
    expb(8'h31, 1, 1);
    repeat (3) cyc();
    FLUSH = 1;
    cyc();
    fc = cyc_n;
    drain(10);
    chk("t3_flush_lat", acc_cyc[0], fc);
    c0 = cyc_n;
    push(8'h32);
    expb(8'h32, 1, 1);
    drain(30);
    chk("t3_next_timing", acc_cyc[1], c0 + TO + 2);
    TX_READY = 0;
    for (int i = 0; i < 6; i++) begin
      push(W'(8'h41 + i));
      expb(W'(8'h41 + i), i == 0 || i == 4, i == 3 || i == 5);
    end
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i >= 1) begin
        chk("t4_data_stable", TX_DATA, 8'h41);
        chk("t4_rd_low", FIFO_RD, 0);
        chk("t4_valid_held", TX_VALID, 1);
      end
    end
    TX_READY = 1;
    drain(40);
    push(8'h51); push(8'h52);
    expb(8'h51, 1, 0); expb(8'h52, 0, 1); expb(8'h53, 1, 1);
    repeat (2) cyc();
    repeat (TO) cyc();
    push(8'h53);
    drain(30);
    push(8'h61); push(8'h62); push(8'h63);
    repeat (2) cyc();
    #2;
    nRST = 0;
    #1;
    chk("t6_valid", TX_VALID, 0);
    chk("t6_sop", TX_SOP, 0);
    chk("t6_eop", TX_EOP, 0);
    chk("t6_data", TX_DATA, 0);
    chk("t6_rd", FIFO_RD, 0);
    repeat (3) cyc();
    chk("t6_fifo_kept", fq.size(), 1);
    nRST = 1;
    expb(8'h63, 1, 1);
    drain(30);
    repeat (5) cyc();
    chk("final_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
